param_cla_adder: RTL and testbench
==================================

PARAM_CLA_ADDER -- requirements
Module: param_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are positive multiples of GROUP.
REQ-002 SHALL have parameter GROUP, default 8, bits resolved per cycle by one lookahead-carry group.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only when accepted (REQ-015).
REQ-006 SHALL have port sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored).
REQ-007 SHALL have port cin  input  1  carry-in for add mode.
REQ-008 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress (RUN state).
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 SHALL accept start when state is IDLE or DONE; on acceptance latch a, b (inverted if sub), carry-in (cin, or 1 if sub), clear group index, enter RUN.
REQ-016 SHALL, in RUN, resolve group k (bits k*GROUP..k*GROUP+GROUP-1) per cycle from latched operands and registered carry, using generate/propagate lookahead carries, never ripple, within the group.
REQ-017 SHALL register group sum bits and group carry-out each RUN cycle; carry-out feeds group k+1 next cycle.
REQ-018 SHALL, with N = WIDTH/GROUP, leave RUN after N cycles to DONE; done high exactly N cycles after the start-accept edge.
REQ-019 SHALL, in DONE, drive done=1 for one cycle and return to IDLE unless a new start is accepted (back-to-back, goes directly to RUN).
REQ-020 SHALL hold sum, cout, ovf stable from done until the next operation's done; partial sums are not visible on sum during RUN.
REQ-021 SHALL ignore start while busy=1; latched operands are not disturbed.
REQ-022 SHALL compute ovf from carry into bit WIDTH-1 and carry out, captured during the final group cycle.
REQ-023 SHALL handle N=1 (WIDTH=GROUP): done one cycle after start accept.
REQ-024 SHALL produce results modulo 2^WIDTH; no saturation.

Reset
REQ-025 SHALL, with rst high at a clock edge, enter IDLE and set busy=0, done=0, sum=0, cout=0, ovf=0, group index=0, carry register=0.
REQ-026 SHALL let rst abort an operation mid-RUN; no done is produced for it.
REQ-027 SHALL give rst priority over start in the same cycle.

Structure
REQ-028 SHALL place state enum (IDLE, RUN, DONE) and default WIDTH/GROUP constants in shared package cla_pkg.
REQ-029 SHALL instantiate one combinational sub-module, group_lookahead_carry, parametrised by GROUP (inputs p, g, cin; outputs carries 1..GROUP).
REQ-030 SHALL reject illegal WIDTH/GROUP combinations at elaboration.

Verification
REQ-031 SHALL cover: WIDTH=32: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, ovf=0, done exactly 4 cycles after start.
REQ-032 SHALL cover: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
REQ-033 SHALL cover: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1, cout=0; a=0x80000000, b=0x80000000 -> sum=0, ovf=1, cout=1.
REQ-034 SHALL cover: start pulsed during busy with other operands -> ignored, first result correct; start held in DONE cycle -> second op done 4 cycles later.
REQ-035 SHALL cover: rst asserted 2 cycles into RUN -> next cycle busy=0, outputs 0, no done pulse.
REQ-036 SHALL cover: WIDTH=16, GROUP=4 and WIDTH=GROUP=8, 1000 random operands each vs reference a+b+cin, latency N.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared FSM state encoding and default sizing for the multi-cycle lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 8;

endpackage

// File: rtl/group_lookahead_carry.sv
// Flat generate/propagate lookahead for one group: every carry is a two-level
// AND-OR of p/g/cin, so no carry depends on another carry output.
module group_lookahead_carry #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic [GROUP:1]   c
);

  always_comb begin
    logic term;
    logic pchain;
    c      = '0;
    term   = 1'b0;
    pchain = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      term   = 1'b0;
      pchain = 1'b1;
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
      for (int j = i; j >= 0; j--) begin
        term   = term | (pchain & g[j]);
        pchain = pchain & p[j];
      end
      c[i+1] = term | (pchain & cin);
    end
  end

endmodule

// File: rtl/param_cla_adder.sv
// Multi-cycle adder/subtractor: one GROUP-bit lookahead slice per cycle, WIDTH/GROUP
// cycles per operation; results appear on sum/cout/ovf only when done pulses.
module param_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / GROUP;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("param_cla_adder: WIDTH must be a positive multiple of GROUP");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa, opb, acc, acc_next;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic               last, accept;
  logic [GROUP-1:0]   gp, gg, gsum;
  logic [GROUP:1]     gc;
  logic [GROUP:0]     cvec;

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign accept = start && !busy;
  assign last   = (idx == IDX_W'(N - 1));

  // Operands shift right each cycle so the active group always sits in the low bits.
  assign gp       = opa[GROUP-1:0] ^ opb[GROUP-1:0];
  assign gg       = opa[GROUP-1:0] & opb[GROUP-1:0];
  assign cvec     = {gc, carry_q};
  assign gsum     = gp ^ cvec[GROUP-1:0];
  assign acc_next = WIDTH'({gsum, acc} >> GROUP);

  group_lookahead_carry #(.GROUP(GROUP)) u_glc (
    .p   (gp),
    .g   (gg),
    .cin (carry_q),
    .c   (gc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      opa     <= a;
      opb     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      idx     <= '0;
    end else if (busy) begin
      opa     <= opa >> GROUP;
      opb     <= opb >> GROUP;
      acc     <= acc_next;
      carry_q <= cvec[GROUP];
      idx     <= idx + IDX_W'(1);
      // Publish only the completed word; partial sums stay in acc.
      if (last) begin
        sum  <= acc_next;
        cout <= cvec[GROUP];
        ovf  <= cvec[GROUP] ^ cvec[GROUP-1];
      end
    end
  end

endmodule

// File: tb/tb_param_cla_adder.sv
// Directed vector table plus corner sequences on a 32/8 instance, and random
// operand sweeps on 16/4 and 8/8 instances against an arithmetic reference.
module tb_param_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start32 = 0, sub32 = 0, cin32 = 0;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        busy32, done32, cout32, ovf32;

  logic        start16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        busy16, done16, cout16, ovf16;

  logic        start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        busy8, done8, cout8, ovf8;

  param_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .cin(cin32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32));

  param_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  param_cla_adder #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done32(inout int lat);
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (done32) break;
    end
    if (!done32) lat = 99;
  endtask

  task automatic run32(input logic [31:0] ia, ib, input logic ic, is, output int lat);
    a32 = ia; b32 = ib; cin32 = ic; sub32 = is; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 0;
    wait_done32(lat);
  endtask

  task automatic run16(input logic [15:0] ia, ib, input logic ic, is, output int lat);
    a16 = ia; b16 = ib; cin16 = ic; sub16 = is; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (done16) break;
    end
    if (!done16) lat = 99;
  endtask

  task automatic run8(input logic [7:0] ia, ib, input logic ic, is, output int lat);
    a8 = ia; b8 = ib; cin8 = ic; sub8 = is; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (done8) break;
    end
    if (!done8) lat = 99;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        co, ov;
  } vec_t;

  vec_t        vt[10];
  int          lat;
  logic        saw;
  logic [15:0] ra16, rb16, bb16;
  logic [16:0] ex16;
  logic [7:0]  ra8, rb8, bb8;
  logic [8:0]  ex8;
  logic        rc, rs, eo;

  initial begin
    //          a             b             cin   sub   sum           cout  ovf
    vt[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vt[6] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[7] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    vt[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[9] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_sum",  sum32,  0);
    chk("rst_cout", cout32, 0);
    chk("rst_ovf",  ovf32,  0);

    for (int i = 0; i < 10; i++) begin
      run32(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, lat);
      chk($sformatf("v%0d_lat", i),  lat,    4);
      chk($sformatf("v%0d_sum", i),  sum32,  vt[i].s);
      chk($sformatf("v%0d_cout", i), cout32, vt[i].co);
      chk($sformatf("v%0d_ovf", i),  ovf32,  vt[i].ov);
    end
    @(posedge clk); #1;
    chk("done_pulse_width", done32, 0);
    chk("idle_after_done",  busy32, 0);

    // start pulsed mid-run with different operands must be ignored
    a32 = 32'd1; b32 = 32'd2; cin32 = 0; sub32 = 0; start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    @(posedge clk); #1;
    lat = 1;
    a32 = 32'd100; b32 = 32'd200; start32 = 1;
    chk("run_sum_hidden", sum32,  32'h01000100);
    chk("run_busy",       busy32, 1);
    @(posedge clk); #1;
    lat = 2;
    start32 = 0; a32 = '0; b32 = '0;
    wait_done32(lat);
    chk("ign_lat", lat,   4);
    chk("ign_sum", sum32, 3);

    // start held during the done cycle goes straight back to RUN
    a32 = 32'h0000FFFF; b32 = 32'h00000001; start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    chk("b2b_busy",     busy32, 1);
    chk("b2b_sum_held", sum32,  3);
    lat = 0;
    wait_done32(lat);
    chk("b2b_lat", lat,   4);
    chk("b2b_sum", sum32, 32'h00010000);

    // reset two cycles into RUN, held together with start
    a32 = 32'h11111111; b32 = 32'h22222222; start32 = 1;
    @(posedge clk); #1;
    start32 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; start32 = 1;
    @(posedge clk); #1;
    chk("abort_busy", busy32, 0);
    chk("abort_sum",  sum32,  0);
    @(posedge clk); #1;
    rst = 0; start32 = 0;
    chk("rst_prio_busy", busy32, 0);
    chk("abort_done",    done32, 0);
    chk("abort_cout",    cout32, 0);
    chk("abort_ovf",     ovf32,  0);
    saw = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done32) saw = 1;
    end
    chk("abort_no_done", saw, 0);
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, lat);
    chk("recover_lat",  lat,    4);
    chk("recover_sum",  sum32,  32'hFFFFFFFF);
    chk("recover_cout", cout32, 1);
    chk("recover_ovf",  ovf32,  0);

    for (int n = 0; n < 1000; n++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      bb16 = rs ? ~rb16 : rb16;
      ex16 = {1'b0, ra16} + {1'b0, bb16} + 17'(rs ? 1'b1 : rc);
      eo   = (ra16[15] == bb16[15]) && (ex16[15] != ra16[15]);
      run16(ra16, rb16, rc, rs, lat);
      chk("r16_lat", lat, 4);
      chk("r16_res", {cout16, ovf16, sum16}, {ex16[16], eo, ex16[15:0]});
    end

    for (int n = 0; n < 1000; n++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      bb8 = rs ? ~rb8 : rb8;
      ex8 = {1'b0, ra8} + {1'b0, bb8} + 9'(rs ? 1'b1 : rc);
      eo  = (ra8[7] == bb8[7]) && (ex8[7] != ra8[7]);
      run8(ra8, rb8, rc, rs, lat);
      chk("r8_lat", lat, 1);
      chk("r8_res", {cout8, ovf8, sum8}, {ex8[8], eo, ex8[7:0]});
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
